// File: rtl/seq_mul.sv
// seq_mul: unsigned radix-2 shift-add multiplier with a fixed latency.
// A start sampled at edge n returns its product with a one-cycle mul_rdy
// pulse from edge n+WIDTH+1. Each multiply runs all WIDTH steps, even
// when an operand is zero, so the latency never depends on the data.
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mul_start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               mul_rdy,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand;   // multiplicand, shifted left once per step
  logic [WIDTH-1:0]   mplier;  // multiplier, shifted right once per step
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;     // number of steps performed so far
  logic               steps_done;

  // The step at cnt == WIDTH-1 is the last one. The next BUSY edge copies
  // the accumulator out and raises mul_rdy.
  assign steps_done = (cnt == CW'(WIDTH));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state. While BUSY, mul_start is ignored, so a start cannot restart
  // an operation in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = mul_start ? BUSY : IDLE;
      BUSY:       if (steps_done) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on a start, then one shift-add step per edge.
  // The operands are read only on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (mul_start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          if (!steps_done) begin
            if (mplier[0]) acc <= acc + mcand;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
            cnt    <= cnt + 1'b1;
          end else begin
            product <= acc;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags, registered. mul_rdy is high only for the single DONE
  // cycle. busy covers the WIDTH cycles that lead directly into that DONE
  // cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_rdy <= 1'b0;
      busy    <= 1'b0;
    end else begin
      mul_rdy <= (state == BUSY) && steps_done;
      busy    <= (state == BUSY) && !steps_done;
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: scoreboard bench for seq_mul (WIDTH=8).
// Stimulus pushes {a*b, due cycle} for each accepted start. A forked
// monitor pops one entry on every mul_rdy and checks the value, the timing
// and the pulse width.
module tb_seq_mul;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mul_start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] product;
  logic           mul_rdy;
  logic           busy;

  seq_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mul_start (mul_start),
    .a         (a),
    .b         (b),
    .product   (product),
    .mul_rdy   (mul_rdy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count of rising edges seen so far. Sampled at negedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint prod;
    int     due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge. The start is sampled at the next edge (n), so the
  // result is due WIDTH+1 edges later, which is observed at negedge cyc+W+2.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    a = av;
    b = bv;
    mul_start = 1'b1;
    e.prod = longint'(av) * longint'(bv);
    e.due  = cyc + W + 2;
    sb.push_back(e);
  endtask

  task automatic monitor();
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mul_rdy) begin
        chk(!prev, "rdy_width", 2, 1);
        if (sb.size() == 0) begin
          chk(1'b0, "spurious_rdy", 1, 0);
        end else begin
          e = sb.pop_front();
          chk(product == e.prod, "product", product, e.prod);
          chk(cyc == e.due, "latency_cycle", cyc, e.due);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        chk(1'b0, "rdy_timeout", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      prev = mul_rdy;
    end
  endtask

  initial begin
    int nb;
    int gap;
    fork
      monitor();
    join_none

    // Reset state, then idle edges with no start after release
    repeat (3) @(negedge clk);
    chk(product == 0, "reset_product", product, 0);
    chk(busy == 0, "reset_busy", busy, 0);
    chk(mul_rdy == 0, "reset_rdy", mul_rdy, 0);
    rst_n = 1'b1;
    nb = 0;
    repeat (4) begin @(negedge clk); nb += int'(busy); end
    chk(nb == 0, "idle_after_release", nb, 0);

    // 13*11: busy high for exactly WIDTH cycles
    issue(8'd13, 8'd11);
    @(negedge clk); mul_start = 1'b0;
    nb = int'(busy);
    repeat (10) begin @(negedge clk); nb += int'(busy); end
    chk(nb == W, "busy_cycles", nb, W);

    // Extremes
    issue(8'd255, 8'd255);
    @(negedge clk); mul_start = 1'b0;
    repeat (10) @(negedge clk);
    issue(8'd0, 8'd200);
    @(negedge clk); mul_start = 1'b0;
    repeat (10) @(negedge clk);
    issue(8'd200, 8'd0);
    @(negedge clk); mul_start = 1'b0;
    repeat (10) @(negedge clk);

    // Start held high and operands changed to 7/7 during BUSY: no restart
    issue(8'd13, 8'd11);
    repeat (W + 1) begin @(negedge clk); a = 8'd7; b = 8'd7; end
    @(negedge clk); mul_start = 1'b0;
    repeat (12) @(negedge clk);
    chk(busy == 0, "held_start_no_restart", busy, 0);

    // Back-to-back start in the mul_rdy cycle; the old product holds meanwhile
    issue(8'd13, 8'd11);
    @(negedge clk); mul_start = 1'b0;
    repeat (W + 1) @(negedge clk);
    issue(8'd3, 8'd5);
    @(negedge clk); mul_start = 1'b0;
    chk(mul_rdy == 0, "b2b_rdy_low", mul_rdy, 0);
    chk(product == 143, "b2b_hold", product, 143);
    repeat (W) begin
      @(negedge clk);
      chk(product == 143, "b2b_hold", product, 143);
    end
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-BUSY
    issue(8'd100, 8'd100);
    @(negedge clk); mul_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(product == 0, "async_rst_product", product, 0);
    chk(busy == 0, "async_rst_busy", busy, 0);
    chk(mul_rdy == 0, "async_rst_rdy", mul_rdy, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    repeat (12) begin @(negedge clk); nb += int'(busy); end
    chk(nb == 0, "post_rst_idle", nb, 0);

    // Randomized operands and gaps. Start and operands are scrambled during BUSY.
    for (int i = 0; i < 1000; i++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      issue(W'($urandom), W'($urandom));
      repeat (W + 1) begin
        @(negedge clk);
        mul_start = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
      end
      @(negedge clk);
      mul_start = 1'b0;
    end

    repeat (15) @(negedge clk);
    chk(sb.size() == 0, "sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
